multi_debounce: RTL

MULTI_DEBOUNCE -- requirements
Module: multi_debounce

---
 rtl/multi_debounce.sv | 108 ++++++++++
 1 files changed

// File: rtl/multi_debounce.sv
// Multi-channel key debouncer: synchroniser, hold-count qualifier,
// edge pulses and optional auto-repeat per channel.
module multi_debounce #(
  parameter int WIDTH         = 4,
  parameter int HOLD          = 100000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic             any_change
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] CMAX = CW'(HOLD - 1);

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] load;
  logic [CW-1:0]    cnt  [WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync[k] <= '0;
    end else begin
      sync[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync[k] <= sync[k-1];
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // load: channel has differed for HOLD samples and flips this edge
  always_comb begin
    load = '0;
    for (int i = 0; i < WIDTH; i++)
      load[i] = (s[i] != out[i]) && (cnt[i] == CMAX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out        <= '0;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++)
        cnt[i] <= '0;
    end else begin
      out        <= out ^ load;
      rise       <= load & s;
      fall       <= load & ~s;
      any_change <= |load;
      for (int i = 0; i < WIDTH; i++) begin
        if ((s[i] == out[i]) || load[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  if (REPEAT_DELAY > 0) begin : g_rpt
    localparam int RMAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LIM = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LIM = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]    rpt [WIDTH];
    logic [WIDTH-1:0] periodic;

    // periodic: first (delay) interval done, now spacing by period
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        repeat_pulse <= '0;
        periodic     <= '0;
        for (int i = 0; i < WIDTH; i++)
          rpt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (!out[i] || load[i]) begin
            rpt[i]          <= '0;
            periodic[i]     <= 1'b0;
            repeat_pulse[i] <= 1'b0;
          end else if (rpt[i] == (periodic[i] ? RP_LIM : RD_LIM)) begin
            rpt[i]          <= '0;
            periodic[i]     <= 1'b1;
            repeat_pulse[i] <= 1'b1;
          end else begin
            rpt[i]          <= rpt[i] + 1'b1;
            repeat_pulse[i] <= 1'b0;
          end
        end
      end
    end
  end else begin : g_norpt
    assign repeat_pulse = '0;
  end

endmodule
